// File: rtl/oh_csa_acc_pkg.sv
// oh_csa_acc_pkg
//   Shared definitions for the carry-save accumulator.
//   Encodings stay as plain 2-bit constants so the state values remain
//   identical to the legacy implementation. The enum is built on top of
//   them.
package oh_csa_acc_pkg;

  localparam logic [1:0] ACC_ENC     = 2'd0;
  localparam logic [1:0] RESOLVE_ENC = 2'd1;
  localparam logic [1:0] OUT_ENC     = 2'd2;

  typedef enum logic [1:0] {
    ST_ACC     = ACC_ENC,
    ST_RESOLVE = RESOLVE_ENC,
    ST_OUT     = OUT_ENC
  } acc_state_e;

endpackage

// File: rtl/oh_csa32.sv
// oh_csa32
//   3:2 carry-save compressor, DW bits wide.
//   Ports:
//     in0, in1, in2 : input  [DW-1:0]  operands
//     s             : output [DW-1:0]  bitwise sum (xor of the three inputs)
//     c             : output [DW-1:0]  bitwise majority (carry, not shifted)
module oh_csa32 #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  output logic [DW-1:0] s,
  output logic [DW-1:0] c
);

  assign s = in0 ^ in1 ^ in2;
  assign c = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/oh_csa_acc.sv
// oh_csa_acc
//   Streaming accumulator. The running sum is kept in redundant
//   sum/carry form so that each accepted operand costs only one 3:2
//   compression. A single carry-propagate add resolves the result once
//   the last operand of a sum has been accepted.
//   Parameters:
//     DW : operand width
//     OW : accumulator/result width (OW >= DW+1)
//   Ports:
//     clk       : input         clock, rising edge
//     reset     : input         synchronous active-high reset
//     in_valid  : input         operand offered
//     in_ready  : output        operand accepted when in_valid & in_ready
//     in_data   : input  [DW]   unsigned operand, zero-extended to OW
//     in_last   : input         accepted operand closes the current sum
//     out_valid : output        result available
//     out_ready : input         result consumed when out_valid & out_ready
//     out_data  : output [OW]   resolved sum modulo 2^OW
//     out_ovf   : output        sticky overflow flag, valid with out_data
//                               (present only with OH_CSA_ACC_OVF_EN)
//   Build macro:
//     OH_CSA_ACC_OVF_EN : adds out_ovf and the overflow tracking logic.
module oh_csa_acc
  import oh_csa_acc_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = DW + 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef OH_CSA_ACC_OVF_EN
  output logic          out_ovf,
`endif
  output logic [OW-1:0] out_data
);

  acc_state_e    state_q, state_d;
  logic [OW-1:0] s_q, s_d;
  logic [OW-1:0] c_q, c_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] x;
  logic [OW-1:0] csa_s, csa_c;
  logic [OW-1:0] resolve_sum;
  logic          accept;
  logic          out_hs;

  assign x = {{(OW-DW){1'b0}}, in_data};

  oh_csa32 #(
    .DW (OW)
  ) u_csa (
    .in0 (s_q),
    .in1 (c_q),
    .in2 (x),
    .s   (csa_s),
    .c   (csa_c)
  );

`ifdef OH_CSA_ACC_OVF_EN
  logic resolve_co;
  logic ovf_q, ovf_d;
  assign {resolve_co, resolve_sum} = {1'b0, s_q} + {1'b0, c_q};
`else
  assign resolve_sum = s_q + c_q;
`endif

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    out_d   = out_q;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          s_d = csa_s;
          // Carry is pre-shifted; the MSB falling off is the modulo wrap.
          c_d = csa_c << 1;
          if (in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        out_d   = resolve_sum;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_hs) begin
          s_d     = '0;
          c_d     = '0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      out_q   <= out_d;
    end
  end

`ifdef OH_CSA_ACC_OVF_EN
  // Any nonzero bit lost from the redundant form means the true sum has
  // exceeded 2^OW, so the flag is the OR of every such loss.
  always_comb begin
    ovf_d = ovf_q;
    unique case (state_q)
      ST_ACC:     if (accept) ovf_d = ovf_q | csa_c[OW-1];
      ST_RESOLVE: ovf_d = ovf_q | resolve_co;
      ST_OUT:     if (out_hs) ovf_d = 1'b0;
      default:    ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_oh_csa_acc.sv
// tb_oh_csa_acc
//   Directed self-checking bench for oh_csa_acc with DW=8, OW=12.
//   Inputs are driven 1 time unit after a rising edge; outputs are
//   sampled at the same point, away from the active edge.
//   Build macro OH_CSA_ACC_OVF_EN additionally exercises out_ovf.
module tb_oh_csa_acc;

  localparam int DW = 8;
  localparam int OW = 12;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
`ifdef OH_CSA_ACC_OVF_EN
  logic          out_ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  oh_csa_acc #(
    .DW (DW),
    .OW (OW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef OH_CSA_ACC_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until an edge accepts it. Returns 1
  // time unit after the accepting edge with in_valid dropped.
  task automatic send(input logic [DW-1:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    else
      pass_cnt++;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 12'h000) $display("FAIL reset_out_data: got %h required 000", out_data);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    step();
    reset = 1'b0;
  endtask

  // Result should be visible two edges after the last operand was
  // presented: one edge to capture it, one to resolve it.
  task automatic check_result(input string name, input logic [OW-1:0] exp);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s_resolve_phase: out_valid=%b in_ready=%b required 0 0", name, out_valid, in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL %s_out_valid: got %b required 1", name, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== exp) $display("FAIL %s_out_data: got %h required %h", name, out_data, exp);
    else pass_cnt++;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL consume: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    check_result("b2b_3xff", 12'h2FD);
    consume();
  endtask

  task automatic test_single();
    send(8'h5A, 1'b1);
    check_result("single_5a", 12'h05A);
`ifdef OH_CSA_ACC_OVF_EN
    total_cnt++;
    if (out_ovf !== 1'b0) $display("FAIL single_ovf: got %b required 0", out_ovf);
    else pass_cnt++;
`endif
    consume();
  endtask

  task automatic test_backpressure();
    send(8'h07, 1'b1);
    check_result("bp_first", 12'h007);
    // Offer a stray operand while the result is pending; it must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 12'h007)
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b out_data=%h required 1 0 007",
                 i, out_valid, in_ready, out_data);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    in_data  = 8'h33;
    consume();
    // Idle cycles with garbage on in_data must not disturb the cleared sum.
    in_last = 1'b1;
    step();
    step();
    in_last = 1'b0;
    send(8'h01, 1'b1);
    check_result("bp_after", 12'h001);
    consume();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    check_result("wrap_17xff", 12'h0EF);
`ifdef OH_CSA_ACC_OVF_EN
    total_cnt++;
    if (out_ovf !== 1'b1) $display("FAIL wrap_ovf: got %b required 1", out_ovf);
    else pass_cnt++;
`endif
    consume();
`ifdef OH_CSA_ACC_OVF_EN
    total_cnt++;
    if (out_ovf !== 1'b0) $display("FAIL wrap_ovf_clear: got %b required 0", out_ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrst_state: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    else pass_cnt++;
    send(8'h03, 1'b1);
    check_result("midrst_acc", 12'h003);
    // Reset wins over a concurrent output handshake and clears the result.
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 12'h000 || in_ready !== 1'b1)
      $display("FAIL midrst_out: out_valid=%b out_data=%h in_ready=%b required 0 000 1",
               out_valid, out_data, in_ready);
    else pass_cnt++;
    send(8'h44, 1'b1);
    check_result("midrst_after", 12'h044);
    consume();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
